// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scoreboard scan back into runs/wickets.
// Optional text glyphs (t, I) for match status are enabled with `define SEG_SCAN_TEXT_EN.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [9:0] runs,
  output logic [3:0] wickets,
  output logic       frame_strobe,
  output logic       frame_valid,
  output logic       decode_err,
  output logic       sep_ok,
  output logic       stale,
  output logic       inning_over,
  output logic       winner_valid,
  output logic       winner
);

  typedef enum logic [1:0] {K_NUM, K_T, K_I, K_BAD} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [3:0] val;
    logic       dot;
  } digit_t;

`ifdef SEG_SCAN_TEXT_EN
  localparam bit TEXT_EN = 1'b1;
`else
  localparam bit TEXT_EN = 1'b0;
`endif

  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES);

  // g is the active-high gfedcba pattern, d the active-high decimal point.
  function automatic digit_t decode(input logic [6:0] g, input logic d);
    digit_t r;
    r.kind = K_NUM;
    r.val  = 4'd0;
    r.dot  = d;
    case (g)
      7'h3F, 7'h00: r.val = 4'd0;
      7'h06: r.val = 4'd1;
      7'h5B: r.val = 4'd2;
      7'h4F: r.val = 4'd3;
      7'h66: r.val = 4'd4;
      7'h6D: r.val = 4'd5;
      7'h7D: r.val = 4'd6;
      7'h07: r.val = 4'd7;
      7'h7F: r.val = 4'd8;
      7'h6F: r.val = 4'd9;
      7'h78: r.kind = TEXT_EN ? K_T : K_BAD;
      7'h30: r.kind = TEXT_EN ? K_I : K_BAD;
      default: r.kind = K_BAD;
    endcase
    return r;
  endfunction

  logic [3:0]    an_s1, an_s2, an_prev;
  logic [6:0]    seg_s1, seg_s2;
  logic          dp_s1, dp_s2;
  logic [CW-1:0] cnt, cnt_next, run_len;
  logic          one_hot, capture;
  logic [1:0]    cap_idx;
  logic [3:0]    mask;
  digit_t [3:0]  digits;
  logic [TW-1:0] to_cnt;
  logic          frame_done, all_num;
  logic [9:0]    runs_calc;

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      an_s1  <= '0;
      an_s2  <= '0;
      seg_s1 <= '0;
      seg_s2 <= '0;
      dp_s1  <= 1'b0;
      dp_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop stage samples the previous stage's old value.
      an_s1  <= an;
      an_s2  <= an_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      dp_s1  <= dp;
      dp_s2  <= dp_s1;
    end
  end

  // run_len: cycles the current synchronized anode value has been held, this cycle included.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    one_hot  = 1'b0;
    cap_idx  = 2'd0;
    case (an_s2)
      4'b1110: begin one_hot = 1'b1; cap_idx = 2'd0; end
      4'b1101: begin one_hot = 1'b1; cap_idx = 2'd1; end
      4'b1011: begin one_hot = 1'b1; cap_idx = 2'd2; end
      4'b0111: begin one_hot = 1'b1; cap_idx = 2'd3; end
      default: ;
    endcase
    run_len  = (an_s2 == an_prev) ? cnt + CW'(1) : CW'(1);
    capture  = one_hot && (run_len == SETTLE);
    cnt_next = !one_hot ? '0 : ((run_len > SETTLE) ? SETTLE : run_len);
  end

  always_comb begin
    frame_done = (mask == 4'b1111);
    all_num    = (digits[3].kind == K_NUM) && (digits[2].kind == K_NUM) &&
                 (digits[1].kind == K_NUM) && (digits[0].kind == K_NUM);
    runs_calc  = 10'(digits[3].val) * 10'd100 + 10'(digits[2].val) * 10'd10 +
                 10'(digits[1].val);
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      an_prev      <= '0;
      cnt          <= '0;
      mask         <= '0;
      digits       <= '0;
      runs         <= '0;
      wickets      <= '0;
      frame_strobe <= 1'b0;
      frame_valid  <= 1'b0;
      decode_err   <= 1'b0;
      sep_ok       <= 1'b0;
      to_cnt       <= '0;
      stale        <= 1'b0;
    end else begin
      an_prev      <= an_s2;
      cnt          <= cnt_next;
      frame_strobe <= frame_done;
      if (capture)
        digits[cap_idx] <= decode(~seg_s2, ~dp_s2);
      // A capture on the completion cycle lands in the freshly cleared mask.
      if (frame_done)
        mask <= capture ? ~an_s2 : 4'b0000;
      else if (capture)
        mask <= mask | ~an_s2;
      if (frame_done) begin
        sep_ok     <= ({digits[3].dot, digits[2].dot, digits[1].dot, digits[0].dot} == 4'b0010);
        decode_err <= !all_num;
        if (all_num) begin
          runs        <= runs_calc;
          wickets     <= digits[0].val;
          frame_valid <= 1'b1;
        end
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TMAX) begin
        to_cnt <= to_cnt + TW'(1);
        stale  <= (to_cnt == TMAX - TW'(1));
      end
    end
  end

`ifdef SEG_SCAN_TEXT_EN
  logic win_frame;
  always_comb begin
    win_frame = (digits[3].kind == K_T) &&
                (digits[2].kind == K_NUM) && (digits[2].val == 4'd0) &&
                (digits[1].kind == K_NUM) && (digits[1].val == 4'd1 || digits[1].val == 4'd2) &&
                (digits[0].kind == K_NUM) && (digits[0].val == 4'd0);
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      inning_over  <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
    end else if (frame_done) begin
      if (win_frame) begin
        winner_valid <= 1'b1;
        winner       <= (digits[1].val == 4'd2);
      end
      if (digits[3].kind == K_I)
        inning_over <= 1'b1;
    end
  end
`else
  assign inning_over  = 1'b0;
  assign winner_valid = 1'b0;
  assign winner       = 1'b0;
`endif

endmodule
